// File: rtl/theta_if.sv
// Lane-serial RAM and start/ready handshake bundle for the theta stage.
// master: the theta engine; slave: the RAM/controller side.
interface theta_if #(
    parameter int unsigned LANE_W = 64
);
    logic              start;
    logic              ready;
    logic              rd_en;
    logic [4:0]        rd_addr;
    logic [LANE_W-1:0] rd_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [LANE_W-1:0] wr_data;

    modport master (
        input  start, rd_data,
        output ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data,
        input  ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/theta.sv
// Keccak-f theta stage: lane-serial column-parity accumulate, D compute, in-place apply.
// THETA_DUAL_PORT_EN defined: overlapped read/write APPLY (53 cycles); undefined: single-port (77 cycles).
module theta #(
    parameter int unsigned LANE_W = 64
) (
    input  logic     clk,
    input  logic     rst,
    theta_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DCALC,
        APPLY
    } state_t;

    state_t state, state_nxt;

    logic [LANE_W-1:0] c_reg [5];
    logic [LANE_W-1:0] d_reg [5];
    logic [4:0]        k;
    logic [2:0]        x;
    logic              ph;
    logic [2:0]        x_inc;

    function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
        return (v << 1) | (v >> (LANE_W - 1));
    endfunction

    // x follows the column of the lane whose data is on rd_data, avoiding a mod-5 divider
    assign x_inc = (x == 3'd4) ? 3'd0 : x + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.ready   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (k < 5'd25) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = k;
                end
                if (k == 5'd25) begin
                    state_nxt = DCALC;
                end
            end
            DCALC: begin
                state_nxt = APPLY;
            end
            APPLY: begin
`ifdef THETA_DUAL_PORT_EN
                if (k < 5'd25) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = k;
                end
                if (k != 5'd0) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = k - 5'd1;
                    bus.wr_data = bus.rd_data ^ d_reg[x];
                end
                if (k == 5'd25) begin
                    state_nxt = IDLE;
                end
`else
                if (!ph) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = k;
                end else begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = k;
                    bus.wr_data = bus.rd_data ^ d_reg[x];
                    if (k == 5'd24) begin
                        state_nxt = IDLE;
                    end
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k  <= '0;
            x  <= '0;
            ph <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                c_reg[i] <= '0;
                d_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k  <= '0;
                        x  <= '0;
                        ph <= 1'b0;
                        for (int unsigned i = 0; i < 5; i++) begin
                            c_reg[i] <= '0;
                        end
                    end
                end
                ACC: begin
                    if (k != 5'd0) begin
                        c_reg[x] <= c_reg[x] ^ bus.rd_data;
                        x        <= x_inc;
                    end
                    k <= (k == 5'd25) ? 5'd0 : k + 5'd1;
                end
                DCALC: begin
                    for (int unsigned i = 0; i < 5; i++) begin
                        d_reg[i] <= c_reg[(i + 4) % 5] ^ rotl1(c_reg[(i + 1) % 5]);
                    end
                    k  <= '0;
                    x  <= '0;
                    ph <= 1'b0;
                end
                APPLY: begin
`ifdef THETA_DUAL_PORT_EN
                    if (k != 5'd0) begin
                        x <= x_inc;
                    end
                    k <= (k == 5'd25) ? 5'd0 : k + 5'd1;
`else
                    ph <= ~ph;
                    if (ph) begin
                        x <= x_inc;
                        k <= (k == 5'd24) ? 5'd0 : k + 5'd1;
                    end
`endif
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule
